alu_wb_stage: RTL and testbench

Registered writeback stage directly downstream of the 32-bit ALU.
- Captures the ALU result, the carryout/overflow/zero flags, the 11-bit op and the destination register index through a valid/ready handshake.
- Buffers results in a 2-entry skid FIFO and presents them to the register file write port.
- Maintains an architectural status register and an overflow trap for signed add/sub.

---
 rtl/alu_wb_stage.sv | 134 +++++++++++++
 tb/tb_alu_wb_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_stage.sv
// Writeback stage behind the 32-bit ALU: 2-entry skid FIFO, status register, overflow trap.
// Optional feature macro: ALU_WB_TRAP_EN (suppress writeback of trapped add/sub, enable ovf_trap/trap_cnt).
module alu_wb_stage #(
    parameter int DW  = 32,
    parameter int OPW = 11,
    parameter int RW  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_op,
    input  logic [DW-1:0]  in_data,
    input  logic           in_carry,
    input  logic           in_ovf,
    input  logic           in_zero,
    input  logic [RW-1:0]  in_dest,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  wb_data,
    output logic [RW-1:0]  wb_dest,
    output logic           wb_en,
    output logic [3:0]     status,
    input  logic           status_clr,
    output logic           ovf_trap,
    output logic [7:0]     trap_cnt
);
    localparam logic [OPW-1:0] OP_ADD = OPW'(11'b00000100000);
    localparam logic [OPW-1:0] OP_SUB = OPW'(11'b00000100010);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] dest;
        logic          v;
        logic          c;
        logic          z;
        logic          trap;
    } ent_t;

    ent_t [1:0] mem;
    ent_t       head;
    logic       rd_ptr, wr_ptr;
    logic [1:0] cnt, cnt_nxt;
    logic       rdy_q;
    logic       push, pop;
    logic       sticky, v_q, c_q, z_q;

    assign push      = in_valid && rdy_q;
    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign in_ready  = rdy_q;
    assign head      = mem[rd_ptr];
    assign wb_data   = head.data;
    assign wb_dest   = head.dest;
    assign status    = {sticky, v_q, c_q, z_q};

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)
            cnt_nxt = cnt + 2'd1;
        else if (pop && !push)
            cnt_nxt = cnt - 2'd1;
    end

    // in_ready is registered from next count, so out_ready never reaches it combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
            rdy_q  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr].data <= in_data;
                mem[wr_ptr].dest <= in_dest;
                mem[wr_ptr].v    <= in_ovf;
                mem[wr_ptr].c    <= in_carry;
                mem[wr_ptr].z    <= in_zero;
                mem[wr_ptr].trap <= in_ovf && ((in_op == OP_ADD) || (in_op == OP_SUB));
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            cnt   <= cnt_nxt;
            rdy_q <= (cnt_nxt != 2'd2);
        end
    end

    // Sticky set on a trapped handshake takes priority over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
            v_q    <= 1'b0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
        end else begin
            if (pop) begin
                v_q <= head.v;
                c_q <= head.c;
                z_q <= head.z;
            end
            if (pop && head.trap)
                sticky <= 1'b1;
            else if (status_clr)
                sticky <= 1'b0;
        end
    end

`ifdef ALU_WB_TRAP_EN
    logic       trap_q;
    logic [7:0] tcnt_q;

    assign wb_en    = out_valid && (head.dest != '0) && !head.trap;
    assign ovf_trap = trap_q;
    assign trap_cnt = tcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
            tcnt_q <= 8'd0;
        end else begin
            trap_q <= pop && head.trap;
            if (pop && head.trap && (tcnt_q != 8'hFF))
                tcnt_q <= tcnt_q + 8'd1;
        end
    end
`else
    assign wb_en    = out_valid && (head.dest != '0);
    assign ovf_trap = 1'b0;
    assign trap_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage; expectations adapt to ALU_WB_TRAP_EN.
module tb_alu_wb_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [10:0] in_op;
    logic [31:0] in_data;
    logic        in_carry, in_ovf, in_zero;
    logic [4:0]  in_dest;
    logic        out_valid, out_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic        wb_en;
    logic [3:0]  status;
    logic        status_clr;
    logic        ovf_trap;
    logic [7:0]  trap_cnt;

    int checks = 0;
    int failures = 0;

    localparam logic [10:0] ADD  = 11'b00000100000;
    localparam logic [10:0] ADDU = 11'b00000100001;
    localparam logic [10:0] SLT  = 11'b00000101010;

`ifdef ALU_WB_TRAP_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    alu_wb_stage #(.DW(32), .OPW(11), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
        .in_carry(in_carry), .in_ovf(in_ovf), .in_zero(in_zero), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_dest(wb_dest), .wb_en(wb_en),
        .status(status), .status_clr(status_clr),
        .ovf_trap(ovf_trap), .trap_cnt(trap_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [10:0] op, input logic [31:0] d, input logic [4:0] dst,
                         input logic c, input logic o, input logic z);
        in_valid = 1'b1; in_op = op; in_data = d; in_dest = dst;
        in_carry = c; in_ovf = o; in_zero = z;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_data = '0; in_carry = 1'b0;
        in_ovf = 1'b0; in_zero = 1'b0; in_dest = '0; out_ready = 1'b0; status_clr = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_status", status, 0);
        chk("rst_trap", {ovf_trap, trap_cnt}, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // single add, 1-cycle latency
        out_ready = 1'b1;
        drive(ADD, 32'h5, 5'd3, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_wb", {wb_data, 3'b0, wb_dest}, {32'h5, 8'd3});
        chk("t1_wb_en", wb_en, 1);
        chk("t1_status", status, 4'b0000);
        tick();
        chk("t1_drained", out_valid, 0);

        // backpressure: three back-to-back with out_ready low
        out_ready = 1'b0;
        drive(ADDU, 32'd10, 5'd1, 0, 0, 0);
        tick();
        drive(ADDU, 32'd11, 5'd2, 0, 0, 0);
        tick();
        chk("bp_full_in_ready", in_ready, 0);
        drive(ADDU, 32'd12, 5'd4, 0, 0, 0);
        tick();
        chk("bp_held_in_ready", in_ready, 0);
        chk("bp_stall_data0", wb_data, 10);
        tick();
        chk("bp_stall_data1", {wb_data, 3'b0, wb_dest}, {32'd10, 8'd1});
        out_ready = 1'b1;
        tick();
        chk("bp_pop0", {wb_data, 3'b0, wb_dest}, {32'd11, 8'd2});
        chk("bp_ready_back", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_pop1", {wb_data, 3'b0, wb_dest}, {32'd12, 8'd4});
        chk("bp_pop1_valid", out_valid, 1);
        tick();
        chk("bp_empty", out_valid, 0);

        // trapped add
        drive(ADD, 32'h8000_0000, 5'd5, 0, 1, 0);
        tick();
        in_valid = 1'b0;
        chk("trap_wb_en", wb_en, !TEN);
        tick();
        chk("trap_status", status, 4'b1100);
        chk("trap_pulse", ovf_trap, TEN);
        chk("trap_cnt1", trap_cnt, TEN ? 8'd1 : 8'd0);
        tick();
        chk("trap_pulse_end", ovf_trap, 0);

        // slt overflow never traps
        drive(SLT, 32'h1, 5'd6, 0, 1, 0);
        tick();
        in_valid = 1'b0;
        chk("slt_wb_en", wb_en, 1);
        tick();
        chk("slt_status", status, 4'b1100);
        chk("slt_no_trap", {ovf_trap, trap_cnt}, TEN ? 9'd1 : 9'd0);

        // dest 0 never writes; carry/zero flags load
        drive(ADDU, 32'h0, 5'd0, 1, 0, 1);
        tick();
        in_valid = 1'b0;
        chk("d0_wb_en", wb_en, 0);
        tick();
        chk("d0_status", status, 4'b1011);

        // clear concurrent with trapped handshake: set wins
        drive(ADD, 32'h7FFF_FFFF, 5'd7, 0, 1, 0);
        tick();
        in_valid = 1'b0;
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        chk("clr_vs_set", status, 4'b1100);
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        chk("clr_alone", status, 4'b0100);

        // saturation: trap_cnt is 2 here when enabled
        drive(ADD, 32'h8000_0000, 5'd9, 0, 1, 0);
        for (int i = 0; i < 252; i++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("sat_fe", trap_cnt, TEN ? 8'hFE : 8'h00);
        drive(ADD, 32'h8000_0000, 5'd9, 0, 1, 0);
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("sat_ff", trap_cnt, TEN ? 8'hFF : 8'h00);

        // reset with two entries buffered
        out_ready = 1'b0;
        drive(ADDU, 32'hAA, 5'd1, 1, 0, 0);
        tick();
        drive(ADDU, 32'hBB, 5'd2, 1, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("mid_full", {out_valid, in_ready}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_wb", {wb_data, wb_dest, wb_en}, 0);
        chk("mid_rst_status", {status, ovf_trap, trap_cnt}, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        #3 rst_n = 1'b1;
        tick();
        chk("mid_rst_after", {in_ready, out_valid}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
